pkt_buffer_writer: RTL and testbench
====================================

Name: pkt_buffer_writer

Overview:
Ingress stage directly upstream of the free-list address manager. Accepts packets on AXI-Stream and writes each word into the shared packet data buffer at the current free-list head. Pulses the manager's write-enable once per stored word. On each packet's last word it emits a descriptor (SOP address, word count) to the scheduler/PIFO.

Parameters:
DATA_WIDTH, 256, AXIS data width in bits.
KEEP_WIDTH, 32, tkeep width (DATA_WIDTH/8).
ADDR_WIDTH, 12, buffer word address width; matches the address manager.
LEN_WIDTH, 12, descriptor length field width in words.
MAX_PKT_WORDS, 48, largest storable packet in words; equals the manager's almost-full threshold.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  ingress data
s_axis_tkeep  in  KEEP_WIDTH  ingress byte enables
s_axis_tvalid  in  1  ingress valid
s_axis_tlast  in  1  ingress last word
s_axis_tready  out  1  ingress ready
s_fl_head  in  ADDR_WIDTH  current free-list head (next writable address)
s_almost_full  in  1  manager almost-full flag
m_fl_wr_en  out  1  to manager write-enable; one pulse per stored word
m_buf_wr_en  out  1  data buffer write strobe
m_buf_wr_addr  out  ADDR_WIDTH  data buffer write address
m_buf_wr_data  out  DATA_WIDTH+KEEP_WIDTH  {tkeep, tdata}
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  descriptor accepted
m_desc_sop_addr  out  ADDR_WIDTH  address of the packet's first word
m_desc_len  out  LEN_WIDTH  stored word count
m_desc_trunc  out  1  packet exceeded MAX_PKT_WORDS and was truncated
m_pkt_count  out  32  descriptors accepted; wraps
m_drop_count  out  32  packets dropped whole; wraps

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; all outputs 0, including counters and descriptor fields. s_axis_tready is 0 while rst is high.
- The manager, this block and the buffer share rst. A reset mid-packet abandons the partial packet; no descriptor is emitted for it.
- beat = s_axis_tvalid & s_axis_tready.
- m_buf_wr_en, m_buf_wr_addr, m_buf_wr_data and m_fl_wr_en are combinational from beat.
  - A word is stored in the same cycle it is accepted, at address s_fl_head.
  - The manager advances s_fl_head for the next cycle.
  - m_fl_wr_en == m_buf_wr_en in every cycle.
- Internal registers: sop_addr, len (LEN_WIDTH), trunc.
- IDLE: tready=1. On a beat (SOP):
  - If s_almost_full=1: nothing is written and the whole packet is dropped. If tlast, increment drop_count and stay in IDLE; otherwise go to DROP_PKT.
  - Otherwise: write the word, sop_addr<=s_fl_head, len<=1, trunc<=0. If tlast, go to DESC; otherwise go to WRITE.
  - Almost-full is sampled only at SOP. The threshold guarantees room for MAX_PKT_WORDS, so a packet never stalls or overflows mid-packet.
- WRITE: tready=1. Each beat writes and does len<=len+1. On tlast, go to DESC.
  - If a beat arrives with len==MAX_PKT_WORDS and no tlast: that word is not written, trunc<=1, go to DROP_TAIL.
- DROP_TAIL: tready=1. Beats are discarded. On tlast, go to DESC; the descriptor reports len=MAX_PKT_WORDS and trunc=1.
- DROP_PKT: tready=1. Beats are discarded. On tlast, increment drop_count and go to IDLE.
- DESC: tready=0. m_desc_valid=1, valid from the cycle after the tlast beat.
  - Fields are stable while valid & ~ready.
  - On m_desc_ready: increment pkt_count, deassert valid, go to IDLE. The next SOP is accepted in the following cycle, giving a minimum 1-cycle gap between packets.
- Latency: tlast beat in cycle N gives m_desc_valid in cycle N+1.
- len never exceeds MAX_PKT_WORDS. Counters wrap modulo 2^32.
- tvalid without tready: no write, no state change.

Decomposition:
- Shared package pkt_buf_pkg: state encoding (IDLE, WRITE, DROP_PKT, DROP_TAIL, DESC), descriptor struct/width {sop_addr, len, trunc}, and default ADDR_WIDTH/MAX_PKT_WORDS constants also used by the address manager and the PIFO.
- No sub-module is required. The FSM, datapath and counters stay in one module (~200 lines).

Test Plan:
- 3-word packet after reset (fl_head 0,1,2), desc_ready=1 → writes at 0,1,2 with three m_fl_wr_en pulses; desc {sop=0, len=3, trunc=0} one cycle after tlast; pkt_count=1.
- 1-word packet (tvalid+tlast at SOP) with fl_head=7 → single write at 7; desc {7, 1, 0}; FSM passes IDLE→DESC→IDLE.
- s_almost_full=1 at SOP of a 5-word packet → no m_buf_wr_en/m_fl_wr_en for any of the 5 beats; drop_count=1; no descriptor; the next packet with almost_full=0 is stored normally.
- 50-word packet, MAX_PKT_WORDS=48 → exactly 48 writes; beats 49–50 discarded; desc {len=48, trunc=1}.
- desc_ready held 0 for 10 cycles after tlast → tready=0 and descriptor fields stable throughout; the next packet's SOP is accepted the cycle after ready rises.
- rst asserted asynchronously mid-way through word 2 of a 4-word packet → outputs 0 immediately; no descriptor; after release a new packet writes at the reset head (0).

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared types and default sizing for the packet-buffer ingress path.
// Also sized against by the free-list address manager and the PIFO descriptor queue.
package pkt_buf_pkg;

   localparam int DFLT_ADDR_WIDTH    = 12;
   localparam int DFLT_LEN_WIDTH     = 12;
   localparam int DFLT_MAX_PKT_WORDS = 48;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_DROP_PKT  = 3'd2,
      ST_DROP_TAIL = 3'd3,
      ST_DESC      = 3'd4
   } state_t;

   typedef struct packed {
      logic [DFLT_ADDR_WIDTH-1:0] sop_addr;
      logic [DFLT_LEN_WIDTH-1:0]  len;
      logic                       trunc;
   } desc_t;

   localparam int DESC_WIDTH = $bits(desc_t);

endpackage

// File: rtl/pkt_buffer_writer.sv
// Writes AXI-Stream words into the packet buffer at the free-list head and emits one descriptor per packet.
// Writes are combinational with the accepted beat; descriptor appears one cycle after tlast; tready drops while a descriptor waits.
module pkt_buffer_writer
   import pkt_buf_pkg::*;
#(
   parameter int DATA_WIDTH    = 256,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH    = DFLT_ADDR_WIDTH,
   parameter int LEN_WIDTH     = DFLT_LEN_WIDTH,
   parameter int MAX_PKT_WORDS = DFLT_MAX_PKT_WORDS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tlast,
   output logic                           s_axis_tready,
   input  logic [ADDR_WIDTH-1:0]          s_fl_head,
   input  logic                           s_almost_full,
   output logic                           m_fl_wr_en,
   output logic                           m_buf_wr_en,
   output logic [ADDR_WIDTH-1:0]          m_buf_wr_addr,
   output logic [DATA_WIDTH+KEEP_WIDTH-1:0] m_buf_wr_data,
   output logic                           m_desc_valid,
   input  logic                           m_desc_ready,
   output logic [ADDR_WIDTH-1:0]          m_desc_sop_addr,
   output logic [LEN_WIDTH-1:0]           m_desc_len,
   output logic                           m_desc_trunc,
   output logic [31:0]                    m_pkt_count,
   output logic [31:0]                    m_drop_count
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] sop_addr;
      logic [LEN_WIDTH-1:0]  len;
      logic                  trunc;
   } desc_fields_t;

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_WORDS);

   state_t       state_q, state_d;
   desc_fields_t desc_q, desc_d;
   logic [31:0]  pkt_count_q, pkt_count_d;
   logic [31:0]  drop_count_q, drop_count_d;
   logic         beat;
   logic         store;

   assign s_axis_tready = ~rst & (state_q != ST_DESC);
   assign beat          = s_axis_tvalid & s_axis_tready;

   always_comb begin
      state_d      = state_q;
      desc_d       = desc_q;
      pkt_count_d  = pkt_count_q;
      drop_count_d = drop_count_q;
      store        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (beat) begin
               // Almost-full is only consulted here; the threshold reserves a full max-size packet.
               if (s_almost_full) begin
                  if (s_axis_tlast) drop_count_d = drop_count_q + 32'd1;
                  else              state_d      = ST_DROP_PKT;
               end else begin
                  store           = 1'b1;
                  desc_d.sop_addr = s_fl_head;
                  desc_d.len      = LEN_WIDTH'(1);
                  desc_d.trunc    = 1'b0;
                  state_d         = s_axis_tlast ? ST_DESC : ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (beat) begin
               // A word beyond the limit is never stored, so len saturates at MAX_LEN.
               if (desc_q.len == MAX_LEN) begin
                  desc_d.trunc = 1'b1;
                  state_d      = s_axis_tlast ? ST_DESC : ST_DROP_TAIL;
               end else begin
                  store      = 1'b1;
                  desc_d.len = desc_q.len + LEN_WIDTH'(1);
                  if (s_axis_tlast) state_d = ST_DESC;
               end
            end
         end
         ST_DROP_TAIL: begin
            if (beat && s_axis_tlast) state_d = ST_DESC;
         end
         ST_DROP_PKT: begin
            if (beat && s_axis_tlast) begin
               drop_count_d = drop_count_q + 32'd1;
               state_d      = ST_IDLE;
            end
         end
         ST_DESC: begin
            if (m_desc_ready) begin
               pkt_count_d = pkt_count_q + 32'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         desc_q       <= '0;
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         desc_q       <= desc_d;
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign m_buf_wr_en     = store;
   assign m_fl_wr_en      = store;
   assign m_buf_wr_addr   = store ? s_fl_head : '0;
   assign m_buf_wr_data   = store ? {s_axis_tkeep, s_axis_tdata} : '0;

   assign m_desc_valid    = (state_q == ST_DESC);
   assign m_desc_sop_addr = desc_q.sop_addr;
   assign m_desc_len      = desc_q.len;
   assign m_desc_trunc    = desc_q.trunc;
   assign m_pkt_count     = pkt_count_q;
   assign m_drop_count    = drop_count_q;

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Scoreboard bench for pkt_buffer_writer with a simple incrementing free-list model.
module tb_pkt_buffer_writer;

   localparam int DW   = 256;
   localparam int KW   = 32;
   localparam int AW   = 12;
   localparam int LW   = 12;
   localparam int MAXW = 48;

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    tdata;
   logic [KW-1:0]    tkeep;
   logic             tvalid;
   logic             tlast;
   logic             tready;
   logic [AW-1:0]    fl_head;
   logic             almost_full;
   logic             fl_wr_en;
   logic             buf_wr_en;
   logic [AW-1:0]    buf_wr_addr;
   logic [DW+KW-1:0] buf_wr_data;
   logic             desc_valid;
   logic             desc_ready;
   logic [AW-1:0]    desc_sop;
   logic [LW-1:0]    desc_len;
   logic             desc_trunc;
   logic [31:0]      pkt_count;
   logic [31:0]      drop_count;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [DW+KW-1:0] data;
   } wr_exp_t;

   typedef struct packed {
      logic [AW-1:0] sop;
      logic [LW-1:0] len;
      logic          trunc;
   } desc_exp_t;

   wr_exp_t   exp_wr_q[$];
   desc_exp_t exp_desc_q[$];

   int            total = 0;
   int            bad = 0;
   int            wr_seen = 0;
   int            exp_pkts = 0;
   int            exp_drops = 0;
   logic [AW-1:0] exp_addr;
   logic [AW-1:0] head_base;
   logic [AW-1:0] head_cnt;

   pkt_buffer_writer #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_PKT_WORDS(MAXW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast), .s_axis_tready(tready),
      .s_fl_head(fl_head), .s_almost_full(almost_full),
      .m_fl_wr_en(fl_wr_en), .m_buf_wr_en(buf_wr_en),
      .m_buf_wr_addr(buf_wr_addr), .m_buf_wr_data(buf_wr_data),
      .m_desc_valid(desc_valid), .m_desc_ready(desc_ready),
      .m_desc_sop_addr(desc_sop), .m_desc_len(desc_len), .m_desc_trunc(desc_trunc),
      .m_pkt_count(pkt_count), .m_drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Free-list manager stand-in: head advances by one per stored word.
   always @(posedge clk or posedge rst) begin
      if (rst)           head_cnt <= '0;
      else if (fl_wr_en) head_cnt <= head_cnt + 1'b1;
   end
   assign fl_head = head_base + head_cnt;

   // Scoreboard pop for the current cycle, then advance to the next falling edge.
   task automatic tick();
      wr_exp_t   w;
      desc_exp_t d;
      #2;
      if (buf_wr_en === 1'b1 || fl_wr_en === 1'b1) begin
         total++;
         if (fl_wr_en !== buf_wr_en) begin
            bad++;
            $display("FAIL wr_en_match: fl_wr_en=%0b buf_wr_en=%0b, required equal", fl_wr_en, buf_wr_en);
         end
      end
      if (buf_wr_en === 1'b1) begin
         wr_seen++;
         total++;
         if (exp_wr_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected: write at addr=%0d, required no write", buf_wr_addr);
         end else begin
            w = exp_wr_q.pop_front();
            if (buf_wr_addr !== w.addr || buf_wr_data !== w.data) begin
               bad++;
               $display("FAIL wr_word: addr=%0d data=%h, required addr=%0d data=%h",
                        buf_wr_addr, buf_wr_data, w.addr, w.data);
            end
         end
      end
      if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
         total++;
         if (exp_desc_q.size() == 0) begin
            bad++;
            $display("FAIL desc_unexpected: sop=%0d len=%0d, required no descriptor", desc_sop, desc_len);
         end else begin
            d = exp_desc_q.pop_front();
            if (desc_sop !== d.sop || desc_len !== d.len || desc_trunc !== d.trunc) begin
               bad++;
               $display("FAIL desc_fields: sop=%0d len=%0d trunc=%0b, required sop=%0d len=%0d trunc=%0b",
                        desc_sop, desc_len, desc_trunc, d.sop, d.len, d.trunc);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic send_pkt(input int n, input logic af);
      int            stored;
      int            waits;
      logic [AW-1:0] sop;
      wr_exp_t       we;
      desc_exp_t     de;
      sop    = exp_addr;
      stored = af ? 0 : ((n > MAXW) ? MAXW : n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < DW / 32; k++) tdata[k*32 +: 32] = $urandom();
         tkeep       = $urandom();
         tvalid      = 1'b1;
         tlast       = (i == n - 1);
         almost_full = af;
         #1;
         waits = 0;
         while (tready !== 1'b1 && waits < 50) begin
            tick();
            #1;
            waits++;
         end
         if (tready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tready_timeout: word %0d of %0d not accepted, tready=%0b required 1", i, n, tready);
            tvalid = 1'b0; tlast = 1'b0; almost_full = 1'b0;
            return;
         end
         if (!af && i < MAXW) begin
            we.addr = exp_addr;
            we.data = {tkeep, tdata};
            exp_wr_q.push_back(we);
            exp_addr++;
         end
         if (i == n - 1) begin
            if (af) exp_drops++;
            else begin
               de.sop   = sop;
               de.len   = LW'(stored);
               de.trunc = (n > MAXW);
               exp_desc_q.push_back(de);
               exp_pkts++;
            end
         end
         tick();
      end
      tvalid = 1'b0; tlast = 1'b0; almost_full = 1'b0;
      #1;
      total++;
      if (desc_valid !== !af) begin
         bad++;
         $display("FAIL desc_latency: desc_valid=%0b one cycle after tlast, required %0b", desc_valid, !af);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tvalid = 1'b1; tlast = 1'b0; almost_full = 1'b0; desc_ready = 1'b1;
      tdata = '1; tkeep = '1; head_base = '0;
      #1;
      total++;
      if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready: %0b required 0", tready); end
      total++;
      if ({buf_wr_en, fl_wr_en, buf_wr_addr, buf_wr_data} !== '0) begin
         bad++; $display("FAIL reset_write: wr_en=%0b addr=%0d, required all 0", buf_wr_en, buf_wr_addr);
      end
      total++;
      if ({desc_valid, desc_sop, desc_len, desc_trunc} !== '0) begin
         bad++; $display("FAIL reset_desc: valid=%0b sop=%0d len=%0d, required all 0", desc_valid, desc_sop, desc_len);
      end
      total++;
      if ({pkt_count, drop_count} !== 64'd0) begin
         bad++; $display("FAIL reset_counts: pkt=%0d drop=%0d, required 0", pkt_count, drop_count);
      end
      tvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (tready !== 1'b1) begin bad++; $display("FAIL idle_tready: %0b required 1", tready); end
      tick();
   endtask

   task automatic check_counts(input string name);
      total++;
      if (pkt_count !== 32'(exp_pkts) || drop_count !== 32'(exp_drops)) begin
         bad++;
         $display("FAIL %s_counts: pkt=%0d drop=%0d, required pkt=%0d drop=%0d",
                  name, pkt_count, drop_count, exp_pkts, exp_drops);
      end
   endtask

   task automatic test_three_word();
      int w0 = wr_seen;
      exp_addr = '0;
      send_pkt(3, 1'b0);
      tick();
      #1;
      check_counts("three_word");
      total++;
      if (wr_seen - w0 != 3) begin bad++; $display("FAIL three_word_writes: %0d required 3", wr_seen - w0); end
      tick();
   endtask

   task automatic test_single_word();
      head_base = AW'(7) - head_cnt;
      exp_addr  = AW'(7);
      send_pkt(1, 1'b0);
      total++;
      if (tready !== 1'b0) begin bad++; $display("FAIL single_desc_tready: %0b required 0", tready); end
      tick();
      #1;
      total++;
      if (tready !== 1'b1 || desc_valid !== 1'b0) begin
         bad++; $display("FAIL single_back_idle: tready=%0b valid=%0b, required 1/0", tready, desc_valid);
      end
      check_counts("single");
      tick();
   endtask

   task automatic test_almost_full_drop();
      int w0 = wr_seen;
      send_pkt(5, 1'b1);
      tick();
      #1;
      check_counts("drop");
      total++;
      if (wr_seen != w0) begin bad++; $display("FAIL drop_writes: %0d required 0", wr_seen - w0); end
      tick();
      send_pkt(2, 1'b0);
      tick();
      #1;
      check_counts("after_drop");
      tick();
   endtask

   task automatic test_truncation();
      int w0 = wr_seen;
      send_pkt(50, 1'b0);
      tick();
      #1;
      total++;
      if (wr_seen - w0 != MAXW) begin bad++; $display("FAIL trunc_writes: %0d required %0d", wr_seen - w0, MAXW); end
      check_counts("trunc");
      tick();
   endtask

   task automatic test_desc_backpressure();
      logic [AW-1:0] sop = exp_addr;
      desc_ready = 1'b0;
      send_pkt(2, 1'b0);
      for (int k = 0; k < 10; k++) begin
         total++;
         if (tready !== 1'b0 || desc_valid !== 1'b1 || desc_sop !== sop || desc_len !== LW'(2) || desc_trunc !== 1'b0) begin
            bad++;
            $display("FAIL desc_hold: cyc=%0d tready=%0b valid=%0b sop=%0d len=%0d trunc=%0b, required 0/1/%0d/2/0",
                     k, tready, desc_valid, desc_sop, desc_len, desc_trunc, sop);
         end
         tick();
         #1;
      end
      desc_ready = 1'b1;
      total++;
      if (tready !== 1'b0) begin bad++; $display("FAIL handshake_tready: %0b required 0", tready); end
      tick();
      #1;
      total++;
      if (tready !== 1'b1 || desc_valid !== 1'b0) begin
         bad++; $display("FAIL after_handshake: tready=%0b valid=%0b, required 1/0", tready, desc_valid);
      end
      send_pkt(1, 1'b0);
      tick();
      #1;
      check_counts("backpressure");
      tick();
   endtask

   task automatic test_async_reset_midpkt();
      wr_exp_t we;
      for (int k = 0; k < DW / 32; k++) tdata[k*32 +: 32] = $urandom();
      tkeep = $urandom(); tvalid = 1'b1; tlast = 1'b0; almost_full = 1'b0;
      #1;
      total++;
      if (tready !== 1'b1) begin bad++; $display("FAIL rst_word1_tready: %0b required 1", tready); end
      we.addr = fl_head;
      we.data = {tkeep, tdata};
      exp_wr_q.push_back(we);
      tick();
      for (int k = 0; k < DW / 32; k++) tdata[k*32 +: 32] = $urandom();
      #1;
      rst = 1'b1;
      #1;
      total++;
      if (tready !== 1'b0 || buf_wr_en !== 1'b0 || fl_wr_en !== 1'b0 || desc_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_rst_outputs: tready=%0b wr=%0b fl=%0b valid=%0b, required 0",
                  tready, buf_wr_en, fl_wr_en, desc_valid);
      end
      total++;
      if ({pkt_count, drop_count} !== 64'd0) begin
         bad++; $display("FAIL async_rst_counts: pkt=%0d drop=%0d, required 0", pkt_count, drop_count);
      end
      tick();
      tvalid = 1'b0;
      tick();
      head_base = '0;
      rst       = 1'b0;
      exp_addr  = '0;
      exp_pkts  = 0;
      exp_drops = 0;
      send_pkt(3, 1'b0);
      tick();
      #1;
      check_counts("post_reset");
      tick();
   endtask

   initial begin
      test_reset();
      test_three_word();
      test_single_word();
      test_almost_full_drop();
      test_truncation();
      test_desc_backpressure();
      test_async_reset_midpkt();
      total++;
      if (exp_wr_q.size() != 0) begin bad++; $display("FAIL wr_leftover: %0d writes missing, required 0", exp_wr_q.size()); end
      total++;
      if (exp_desc_q.size() != 0) begin bad++; $display("FAIL desc_leftover: %0d descriptors missing, required 0", exp_desc_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
